uart_txq: RTL and testbench

- Byte transmit queue sitting directly upstream of the UART transmitter.
- The host bus pushes characters and a baud-rate word into this block without waiting.
- A drain FSM polls the UART's busy status bit, then issues the 32-bit {rate, byte} write the UART expects, one byte per character.
- Decouples firmware console output from the serial bit rate.

---
 rtl/uart_txq_pkg.sv | 32 +++
 rtl/uart_txq_fifo.sv | 59 +++++
 rtl/uart_txq.sv | 197 +++++++++++++++++++
 tb/tb_uart_txq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_txq_pkg.sv
// uart_txq_pkg: shared definitions for the UART transmit queue.
//   - drain FSM state encoding
//   - host register addresses
//   - status word bit positions
//   - character constants used by the optional LF -> CR LF expansion
package uart_txq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_POLL  = 2'd1,
    S_WRITE = 2'd2,
    S_GAP   = 2'd3
  } txq_state_t;

  localparam logic ADR_DATA = 1'b0;
  localparam logic ADR_RATE = 1'b1;

  localparam int ST_EMPTY  = 16;
  localparam int ST_FULL   = 17;
  localparam int ST_OVF    = 18;
  localparam int ST_ACTIVE = 19;

  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_CR = 8'h0D;

  // Word format the UART expects on a write.
  function automatic logic [31:0] uart_word(input logic [23:0] rate,
                                            input logic [7:0]  chr);
    return {rate, chr};
  endfunction

endpackage

// File: rtl/uart_txq_fifo.sv
// uart_txq_fifo: synchronous 8-bit FIFO, 2^DEPTH_LOG2 entries.
// Ports:
//   clk, rst_n        clock, async active-low reset (empties the FIFO)
//   i_push, i_din     write request / byte; ignored while full
//   i_pop             read request; ignored while empty
//   o_dout            head byte (valid when !o_empty)
//   o_full, o_empty   occupancy flags
//   o_level           entry count, DEPTH_LOG2+1 bits
module uart_txq_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [7:0]            i_din,
  input  logic                  i_pop,
  output logic [7:0]            o_dout,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]          r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DEPTH_LOG2:0] r_wptr;
  logic [DEPTH_LOG2:0] r_rptr;
  logic [DEPTH_LOG2:0] w_level;
  logic                w_do_push;
  logic                w_do_pop;

  assign w_level = r_wptr - r_rptr;
  // Level never exceeds DEPTH, so its top bit alone means full.
  assign o_full  = w_level[DEPTH_LOG2];
  assign o_empty = (w_level == '0);
  assign o_level = w_level;
  assign o_dout  = r_mem[r_rptr[DEPTH_LOG2-1:0]];

  // Full is judged before any same-cycle pop: a push into a full FIFO is lost.
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[DEPTH_LOG2-1:0]] <= i_din;
  end

endmodule

// File: rtl/uart_txq.sv
// uart_txq: byte transmit queue in front of the UART transmitter.
// Host side pushes bytes (adr 0) and sets the baud-rate word (adr 1) with
// zero wait states; a drain FSM polls the UART busy bit and writes
// {rate, byte} once per character.
// Ports:
//   sys_clk_i, sys_rst_n_i           clock, async active-low reset
//   txq_stb_i/wea_i/adr_i/dat_i      host access
//   txq_ack_o, txq_dat_o             host ack (= strobe), read data
//   uart_stb_o/wea_o/dat_o           registered access to the UART
//   uart_ack_i, uart_dat_i           UART ack, read data (bit 0 = busy)
// Optional: define UART_TXQ_CRLF_EN to send CR before every LF.
module uart_txq
  import uart_txq_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [23:0] RATE_RST   = 24'h000800
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        txq_stb_i,
  input  logic        txq_wea_i,
  input  logic        txq_adr_i,
  input  logic [31:0] txq_dat_i,
  output logic        txq_ack_o,
  output logic [31:0] txq_dat_o,
  output logic        uart_stb_o,
  output logic        uart_wea_o,
  output logic [31:0] uart_dat_o,
  input  logic        uart_ack_i,
  input  logic [31:0] uart_dat_i
);

  // ---------------- host side ----------------
  logic        w_push;
  logic        w_rate_wr;
  logic        w_stat_rd;
  logic        w_pop;
  logic [7:0]  w_head;
  logic        w_full;
  logic        w_empty;
  logic [DEPTH_LOG2:0] w_level;
  logic [23:0] r_rate;
  logic        r_ovf;
  logic [31:0] w_rd;
  logic        w_unused;

  assign w_unused  = &{1'b0, txq_dat_i[31:24], uart_dat_i[31:1]};

  assign txq_ack_o = txq_stb_i;
  assign w_push    = txq_stb_i &&  txq_wea_i && (txq_adr_i == ADR_DATA);
  assign w_rate_wr = txq_stb_i &&  txq_wea_i && (txq_adr_i == ADR_RATE);
  assign w_stat_rd = txq_stb_i && !txq_wea_i && (txq_adr_i == ADR_DATA);

  uart_txq_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk     (sys_clk_i),
    .rst_n   (sys_rst_n_i),
    .i_push  (w_push),
    .i_din   (txq_dat_i[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_rate <= RATE_RST;
      r_ovf  <= 1'b0;
    end else begin
      if (w_rate_wr) r_rate <= txq_dat_i[23:0];
      // Set and clear come from a write and a read, so they never collide.
      if (w_push && w_full) r_ovf <= 1'b1;
      else if (w_stat_rd)   r_ovf <= 1'b0;
    end
  end

  // ---------------- drain FSM ----------------
  txq_state_t  r_state, w_nxt_state;
  logic        r_stb, w_nxt_stb;
  logic        r_wea, w_nxt_wea;
  logic [31:0] r_dat, w_nxt_dat;
  logic [7:0]  w_send;
  logic        w_busy;

  assign w_busy = uart_dat_i[0];

`ifdef UART_TXQ_CRLF_EN
  // cr_done marks that the CR for the LF at the head has already gone out.
  logic r_cr_done, w_nxt_cr_done;
  logic w_lf_sub;
  assign w_lf_sub = (w_head == CHR_LF) && !r_cr_done;
  assign w_send   = w_lf_sub ? CHR_CR : w_head;
`else
  assign w_send   = w_head;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_stb   = r_stb;
    w_nxt_wea   = r_wea;
    w_nxt_dat   = r_dat;
    w_pop       = 1'b0;
`ifdef UART_TXQ_CRLF_EN
    w_nxt_cr_done = r_cr_done;
`endif
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_nxt_state = S_POLL;
          w_nxt_stb   = 1'b1;
          w_nxt_wea   = 1'b0;
        end
      end
      S_POLL: begin
        // Busy keeps us polling; the strobe stays up for a fresh read.
        if (uart_ack_i && !w_busy) begin
          w_nxt_state = S_WRITE;
          w_nxt_stb   = 1'b1;
          w_nxt_wea   = 1'b1;
          // Rate is captured here, so later rate writes miss this byte.
          w_nxt_dat   = uart_word(r_rate, w_send);
        end
      end
      S_WRITE: begin
        if (uart_ack_i) begin
          w_nxt_state = S_GAP;
          w_nxt_stb   = 1'b0;
          w_nxt_wea   = 1'b0;
`ifdef UART_TXQ_CRLF_EN
          if (w_lf_sub) begin
            w_nxt_cr_done = 1'b1;
          end else begin
            w_pop         = 1'b1;
            w_nxt_cr_done = 1'b0;
          end
`else
          w_pop = 1'b1;
`endif
        end
      end
      S_GAP: begin
        // One idle cycle lets the UART's busy flag reflect the last write.
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_stb   = 1'b0;
        w_nxt_wea   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      r_state <= S_IDLE;
      r_stb   <= 1'b0;
      r_wea   <= 1'b0;
      r_dat   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_stb   <= w_nxt_stb;
      r_wea   <= w_nxt_wea;
      r_dat   <= w_nxt_dat;
    end
  end

`ifdef UART_TXQ_CRLF_EN
  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) r_cr_done <= 1'b0;
    else              r_cr_done <= w_nxt_cr_done;
  end
`endif

  assign uart_stb_o = r_stb;
  assign uart_wea_o = r_wea;
  assign uart_dat_o = r_dat;

  // ---------------- host read mux ----------------
  always_comb begin
    w_rd = '0;
    if (txq_stb_i && !txq_wea_i) begin
      if (txq_adr_i == ADR_DATA) begin
        w_rd[DEPTH_LOG2:0] = w_level;
        w_rd[ST_EMPTY]     = w_empty;
        w_rd[ST_FULL]      = w_full;
        w_rd[ST_OVF]       = r_ovf;
        w_rd[ST_ACTIVE]    = (r_state != S_IDLE);
      end else begin
        w_rd = {8'h00, r_rate};
      end
    end
  end

  assign txq_dat_o = w_rd;

endmodule

// File: tb/tb_uart_txq.sv
// tb_uart_txq: scoreboard bench for uart_txq. Stimulus pushes expected UART
// writes into a queue; a monitor pops and compares on every UART write.
module tb_uart_txq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, wea = 1'b0, adr = 1'b0;
  logic [31:0] dat = '0;
  logic        ack;
  logic [31:0] rdat;
  logic        u_stb, u_wea;
  logic [31:0] u_dat;
  logic        u_ack;
  logic [31:0] u_rdat;
  logic        busy = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] dat;
    int          cyc;   // -1: timing not checked
  } exp_t;

  exp_t sb[$];
  exp_t m_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // UART model: acks every access at once, busy under bench control.
  assign u_ack  = u_stb;
  assign u_rdat = {31'b0, busy};

  uart_txq dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .txq_stb_i   (stb),
    .txq_wea_i   (wea),
    .txq_adr_i   (adr),
    .txq_dat_i   (dat),
    .txq_ack_o   (ack),
    .txq_dat_o   (rdat),
    .uart_stb_o  (u_stb),
    .uart_wea_o  (u_wea),
    .uart_dat_o  (u_dat),
    .uart_ack_i  (u_ack),
    .uart_dat_i  (u_rdat)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted UART write is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && u_stb && u_wea && u_ack) begin
      check("uart_wr_not_busy", {31'b0, busy}, 32'd0);
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL uart_wr_unexpected: got %h expected none", u_dat);
      end else begin
        m_e = sb.pop_front();
        check("uart_wr_data", u_dat, m_e.dat);
        if (m_e.cyc >= 0) check("uart_wr_latency", cyc, m_e.cyc);
      end
    end
  end

  task automatic host_wr(input logic a, input logic [31:0] d, output int c);
    @(negedge clk);
    stb = 1'b1; wea = 1'b1; adr = a; dat = d;
    @(negedge clk);
    stb = 1'b0; wea = 1'b0; dat = '0;
    c = cyc;
  endtask

  // Push one byte; optionally record the expected write (timed = exact cycle).
  task automatic push(input logic [7:0] b, input logic [23:0] rate,
                      input bit expect_tx, input bit timed);
    int c;
    exp_t e;
    host_wr(1'b0, {24'hABCDEF, b}, c);
    if (expect_tx) begin
      e.dat = {rate, b};
      e.cyc = timed ? c + 2 : -1;
      sb.push_back(e);
    end
  endtask

  task automatic host_rd(input logic a, input logic [31:0] exp, input string name);
    @(negedge clk);
    stb = 1'b1; wea = 1'b0; adr = a;
    #1;
    check(name, rdat, exp);
    check({name, "_ack"}, {31'b0, ack}, 32'd1);
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int   c;
    bit   found;
    exp_t e;

    // Reset state
    wait_cyc(3);
    rst_n = 1'b1;
    #1;
    check("rst_uart_stb", {31'b0, u_stb}, 32'd0);
    check("rst_uart_wea", {31'b0, u_wea}, 32'd0);
    check("rst_uart_dat", u_dat, 32'd0);
    host_rd(1'b0, 32'h0001_0000, "rst_status");
    host_rd(1'b1, 32'h0000_0800, "rst_rate");

    // Single byte, idle UART, exact latency
    host_wr(1'b1, 32'hFF00_4000, c);
    host_rd(1'b1, 32'h0000_4000, "rate_rb");
    push(8'h41, 24'h004000, 1'b1, 1'b1);
    wait_cyc(4);
    host_rd(1'b0, 32'h0001_0000, "single_done_status");

    // UART busy: polling only, then in-order drain
    busy = 1'b1;
    push(8'h42, 24'h004000, 1'b1, 1'b0);
    push(8'h43, 24'h004000, 1'b1, 1'b0);
    wait_cyc(100);
    check("busy_polling", {30'b0, u_stb, u_wea}, 32'd2);
    host_rd(1'b0, 32'h0008_0002, "busy_status");
    busy = 1'b0;
    wait_cyc(20);
    check("busy_drained", sb.size(), 32'd0);
    host_rd(1'b0, 32'h0001_0000, "busy_done_status");

    // Overflow: 17 pushes, only 16 survive
    busy = 1'b1;
    for (int i = 0; i < 17; i++)
      push(8'h50 + 8'(i), 24'h004000, (i < 16), 1'b0);
    host_rd(1'b0, 32'h000E_0010, "ovf_status1");
    host_rd(1'b0, 32'h000A_0010, "ovf_status2");
    busy = 1'b0;
    wait_cyc(100);
    check("ovf_drained", sb.size(), 32'd0);
    host_rd(1'b0, 32'h0001_0000, "ovf_done_status");

    // Simultaneous push and pop at level 5
    busy = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 24'h004000, 1'b1, 1'b0);
    host_rd(1'b0, 32'h0008_0005, "lvl5_before");
    busy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (u_stb && u_wea) begin
        found = 1'b1;
        break;
      end
    end
    check("lvl5_write_seen", {31'b0, found}, 32'd1);
    stb = 1'b1; wea = 1'b1; adr = 1'b0; dat = 32'h0000_0065;
    e.dat = 32'h0040_0065; e.cyc = -1;
    sb.push_back(e);
    @(negedge clk);
    busy = 1'b1;
    wea = 1'b0; dat = '0;
    #1;
    check("lvl5_after", rdat, 32'h0008_0005);
    @(negedge clk);
    stb = 1'b0;
    busy = 1'b0;
    wait_cyc(40);
    check("lvl5_drained", sb.size(), 32'd0);

    // Reset in the middle of POLL
    busy = 1'b1;
    push(8'h70, 24'h004000, 1'b0, 1'b0);
    wait_cyc(3);
    check("pre_rst_poll", {30'b0, u_stb, u_wea}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_stb", {31'b0, u_stb}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy = 1'b0;
    host_rd(1'b0, 32'h0001_0000, "post_rst_status");
    host_rd(1'b1, 32'h0000_0800, "post_rst_rate");
    wait_cyc(10);

    // Line feed handling
`ifdef UART_TXQ_CRLF_EN
    e.dat = 32'h0008_000D; e.cyc = -1;
    sb.push_back(e);
`endif
    push(8'h0A, 24'h000800, 1'b1, 1'b0);
    wait_cyc(20);
    check("lf_drained", sb.size(), 32'd0);
    host_rd(1'b0, 32'h0001_0000, "final_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

endmodule
